lin_header_receiver: RTL and testbench

Responder-side LIN header decoder. It consumes the 10-bit symbol stream that the commander header generator drives: break symbol 1, break symbol 2, sync, then the protected identifier (PID). It validates each symbol, checks PID parity, and presents the 6-bit frame ID with a one-cycle valid strobe to the responder's frame-response logic. Errors are flagged per header, and the block resynchronises on the next break.

---
 rtl/lin_pkg.sv | 31 +++
 rtl/lin_pid_parity.sv | 18 +
 rtl/lin_header_receiver.sv | 162 ++++++++++++++++
 tb/tb_lin_header_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lin_pkg.sv
// -----------------------------------------------------------------------------
// lin_pkg
// Shared LIN definitions used by both the commander header generator and the
// responder header receiver: fixed header symbols, 10-bit symbol field
// positions and the receiver state encoding.
// -----------------------------------------------------------------------------
package lin_pkg;

  localparam int LIN_SYM_W = 10;

  // Fixed header symbols (start bit in [0], stop bit in [9]).
  localparam logic [LIN_SYM_W-1:0] LIN_BRK1 = 10'h000;
  localparam logic [LIN_SYM_W-1:0] LIN_BRK2 = 10'h200;
  localparam logic [LIN_SYM_W-1:0] LIN_SYNC = 10'h2AA;

  // Symbol field indices.
  localparam int SYM_START  = 0;
  localparam int SYM_STOP   = 9;
  localparam int PID_ID_LSB = 1;
  localparam int PID_ID_MSB = 6;
  localparam int PID_P0     = 7;
  localparam int PID_P1     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BRK    = 2'd1,
    ST_SYNC_W = 2'd2,
    ST_PID_W  = 2'd3
  } lin_rx_state_e;

endpackage : lin_pkg

// File: rtl/lin_pid_parity.sv
// -----------------------------------------------------------------------------
// lin_pid_parity
// Combinational LIN protected-identifier parity. Used by both the header
// generator and the receiver so the two ends agree by construction.
//   id_i     [5:0]  frame ID
//   parity_o [1:0]  {P1, P0}
// -----------------------------------------------------------------------------
module lin_pid_parity (
  input  logic [5:0] id_i,
  output logic [1:0] parity_o
);

  always_comb begin
    parity_o[0] = id_i[0] ^ id_i[1] ^ id_i[2] ^ id_i[4];
    parity_o[1] = ~(id_i[1] ^ id_i[3] ^ id_i[4] ^ id_i[5]);
  end

endmodule : lin_pid_parity

// File: rtl/lin_header_receiver.sv
// -----------------------------------------------------------------------------
// lin_header_receiver
// Responder-side LIN header decoder. Walks BRK1 -> BRK2 -> SYNC -> PID,
// checks the PID framing and parity, and reports the frame ID with a one-cycle
// header_valid strobe or one-cycle error pulses. An inter-symbol gap longer
// than GAP_MAX idle cycles aborts the header.
//   clk, reset    clock, synchronous active-high reset
//   sym_in        received 10-bit symbol, qualified by sym_valid
//   pid_id        last received frame ID (held between headers)
//   pid_parity    last received {P1,P0}
//   header_valid  pulse: header complete without error
//   parity_err    pulse: PID parity mismatch
//   sync_err      pulse: symbol after the break was not SYNC
//   framing_err   pulse: PID start bit != 0 or stop bit != 1
//   timeout_err   pulse: inter-symbol gap exceeded GAP_MAX
//   busy          receiver is inside a header (state != IDLE)
// -----------------------------------------------------------------------------
module lin_header_receiver
  import lin_pkg::*;
#(
  parameter int SYM_W   = 10,
  parameter int GAP_MAX = 4,
  parameter int GAP_CW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic [5:0]       pid_id,
  output logic [1:0]       pid_parity,
  output logic             header_valid,
  output logic             parity_err,
  output logic             sync_err,
  output logic             framing_err,
  output logic             timeout_err,
  output logic             busy
);

  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_MAX - 1);
  localparam logic [GAP_CW-1:0] GAP_SAT  = {GAP_CW{1'b1}};

  lin_rx_state_e     state_q, state_d;
  logic [GAP_CW-1:0] gap_q, gap_d;
  logic [5:0]        pid_id_q, pid_id_d;
  logic [1:0]        pid_par_q, pid_par_d;
  logic              hv_q, hv_d;
  logic              pe_q, pe_d;
  logic              se_q, se_d;
  logic              fe_q, fe_d;
  logic              te_q, te_d;

  logic [5:0] rx_id;
  logic [1:0] rx_par;
  logic [1:0] exp_par;

  assign rx_id  = sym_in[PID_ID_MSB:PID_ID_LSB];
  assign rx_par = {sym_in[PID_P1], sym_in[PID_P0]};

  lin_pid_parity u_parity (
    .id_i     (rx_id),
    .parity_o (exp_par)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    gap_d     = gap_q;
    pid_id_d  = pid_id_q;
    pid_par_d = pid_par_q;
    hv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    fe_d      = 1'b0;
    te_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sym_valid && sym_in == LIN_BRK1) state_d = ST_BRK;
      end
      ST_BRK: begin
        if (sym_valid) begin
          if (sym_in == LIN_BRK2)      state_d = ST_SYNC_W;
          else if (sym_in == LIN_BRK1) state_d = ST_BRK;  // extended break
          else                         state_d = ST_IDLE;
        end
      end
      ST_SYNC_W: begin
        if (sym_valid) begin
          if (sym_in == LIN_SYNC) begin
            state_d = ST_PID_W;
          end else begin
            se_d    = 1'b1;
            // A fresh BRK1 here is treated as the start of the next header.
            state_d = (sym_in == LIN_BRK1) ? ST_BRK : ST_IDLE;
          end
        end
      end
      ST_PID_W: begin
        if (sym_valid) begin
          pid_id_d  = rx_id;
          pid_par_d = rx_par;
          fe_d      = sym_in[SYM_START] | ~sym_in[SYM_STOP];
          pe_d      = (rx_par != exp_par);
          hv_d      = (sym_in[SYM_START] == 1'b0) && sym_in[SYM_STOP] &&
                      (rx_par == exp_par);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Gap counter: held at zero while idle, cleared by any symbol, otherwise
    // counts idle cycles. The cycle that would bring it to GAP_MAX aborts the
    // header instead; a symbol in that same cycle takes priority.
    if (state_q == ST_IDLE || sym_valid) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      te_d    = 1'b1;
      state_d = ST_IDLE;
      gap_d   = '0;
    end else if (gap_q != GAP_SAT) begin
      gap_d = gap_q + GAP_CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      pid_id_q  <= '0;
      pid_par_q <= '0;
      hv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      fe_q      <= 1'b0;
      te_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pid_id_q  <= pid_id_d;
      pid_par_q <= pid_par_d;
      hv_q      <= hv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      fe_q      <= fe_d;
      te_q      <= te_d;
    end
  end

  assign pid_id       = pid_id_q;
  assign pid_parity   = pid_par_q;
  assign header_valid = hv_q;
  assign parity_err   = pe_q;
  assign sync_err     = se_q;
  assign framing_err  = fe_q;
  assign timeout_err  = te_q;
  assign busy         = (state_q != ST_IDLE);

endmodule : lin_header_receiver

// File: tb/tb_lin_header_receiver.sv
// -----------------------------------------------------------------------------
// tb_lin_header_receiver
// Directed, table-driven bench for lin_header_receiver. Each table row is one
// clock cycle of stimulus plus the registered outputs expected right after
// that cycle's rising edge. Hand-written sequences cover reset mid-header and
// a timeout while waiting for the PID.
// Reference PIDs (stop=1, start=0, {P1,P0} from the parity equations):
//   ID 0x3C -> P1=0 P0=0 -> 10'h278 ; ID 0x01 -> P1=1 P0=1 -> 10'h382
// -----------------------------------------------------------------------------
module tb_lin_header_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic [5:0] pid_id;
  logic [1:0] pid_parity;
  logic       header_valid, parity_err, sync_err, framing_err, timeout_err, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lin_header_receiver #(.SYM_W(10), .GAP_MAX(4), .GAP_CW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .pid_id       (pid_id),
    .pid_parity   (pid_parity),
    .header_valid (header_valid),
    .parity_err   (parity_err),
    .sync_err     (sync_err),
    .framing_err  (framing_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  // Flags order: {header_valid, parity_err, sync_err, framing_err, timeout_err, busy}
  typedef struct packed {
    logic [9:0] sym;
    logic       valid;
    logic [5:0] id;
    logic [1:0] par;
    logic [5:0] flags;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [9:0] s, input logic v,
                              input logic [5:0] id, input logic [1:0] par,
                              input logic [5:0] flags);
    vec_t r;
    r.sym = s; r.valid = v; r.id = id; r.par = par; r.flags = flags;
    return r;
  endfunction

  function automatic logic [13:0] observe();
    return {pid_id, pid_parity, header_valid, parity_err, sync_err,
            framing_err, timeout_err, busy};
  endfunction

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got id=%h par=%b flags=%b, expected id=%h par=%b flags=%b",
               name, act[13:8], act[7:6], act[5:0], exp[13:8], exp[7:6], exp[5:0]);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, then sample #1 after the
  // following rising edge.
  task automatic step(input logic [9:0] s, input logic v);
    @(negedge clk);
    sym_in    = s;
    sym_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [9:0] s, input logic v,
                          input logic [5:0] id, input logic [1:0] par,
                          input logic [5:0] flags);
    step(s, v);
    check(name, observe(), {id, par, flags});
  endtask

  initial begin
    reset     = 1'b1;
    sym_in    = '0;
    sym_valid = 1'b0;
    step(10'h000, 1'b1);
    step(10'h000, 1'b1);
    check("reset_state", observe(), 14'h0);
    reset = 1'b0;

    // Clean header, then back-to-back header carrying a parity error.
    tbl.push_back(mk(10'h000, 1, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h278, 1, 6'h3C, 2'b00, 6'b100000));
    tbl.push_back(mk(10'h000, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h378, 1, 6'h3C, 2'b10, 6'b010000));
    // Next clean header accepted (ID 0x01).
    tbl.push_back(mk(10'h000, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h382, 1, 6'h01, 2'b11, 6'b100000));
    // Bad sync, then a full header.
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h2AB, 1, 6'h01, 2'b11, 6'b001000));
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h382, 1, 6'h01, 2'b11, 6'b100000));
    // BRK1 where SYNC is expected: sync_err and restart in BRK.
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b001001));
    tbl.push_back(mk(10'h200, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h01, 2'b11, 6'b000001));
    // Start bit set, parity fine: framing only.
    tbl.push_back(mk(10'h279, 1, 6'h3C, 2'b00, 6'b000100));
    // Start bit set and P1 wrong: parity and framing together.
    tbl.push_back(mk(10'h000, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h3C, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h379, 1, 6'h3C, 2'b10, 6'b010100));
    // Extended break.
    tbl.push_back(mk(10'h000, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h000, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h3C, 2'b10, 6'b000001));
    tbl.push_back(mk(10'h382, 1, 6'h01, 2'b11, 6'b100000));
    // Junk after break: silent return to IDLE; junk in IDLE ignored.
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h123, 1, 6'h01, 2'b11, 6'b000000));
    tbl.push_back(mk(10'h2AA, 1, 6'h01, 2'b11, 6'b000000));
    // BRK1 as PID: stop bit 0 and ID 0 expects P1=1 -> framing + parity.
    tbl.push_back(mk(10'h000, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h2AA, 1, 6'h01, 2'b11, 6'b000001));
    tbl.push_back(mk(10'h000, 1, 6'h00, 2'b00, 6'b010100));
    // Unqualified BRK1 does not start a header.
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000000));
    // Gap of 3 then a symbol: no timeout. Gap of 4: timeout, one cycle pulse.
    tbl.push_back(mk(10'h000, 1, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h200, 1, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000001));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000010));
    tbl.push_back(mk(10'h000, 0, 6'h00, 2'b00, 6'b000000));

    foreach (tbl[i]) begin
      step(tbl[i].sym, tbl[i].valid);
      check($sformatf("vec%0d", i), observe(), {tbl[i].id, tbl[i].par, tbl[i].flags});
    end

    // Timeout while waiting for the PID keeps pid_id; next header decodes.
    step_chk("pw_brk1",  10'h000, 1, 6'h00, 2'b00, 6'b000001);
    step_chk("pw_brk2",  10'h200, 1, 6'h00, 2'b00, 6'b000001);
    step_chk("pw_sync",  10'h2AA, 1, 6'h00, 2'b00, 6'b000001);
    for (int k = 0; k < 3; k++) step(10'h000, 1'b0);
    step_chk("pw_tmo",   10'h000, 0, 6'h00, 2'b00, 6'b000010);
    step_chk("pw_hdr_b", 10'h000, 1, 6'h00, 2'b00, 6'b000001);
    step(10'h200, 1'b1);
    step(10'h2AA, 1'b1);
    step_chk("pw_hdr_p", 10'h382, 1, 6'h01, 2'b11, 6'b100000);

    // Reset after sync discards the header and clears pid_id silently.
    step(10'h000, 1'b1);
    step(10'h200, 1'b1);
    step_chk("rm_sync", 10'h2AA, 1, 6'h01, 2'b11, 6'b000001);
    reset = 1'b1;
    step_chk("rm_rst",  10'h278, 1, 6'h00, 2'b00, 6'b000000);
    reset = 1'b0;
    step_chk("rm_post", 10'h000, 0, 6'h00, 2'b00, 6'b000000);
    step(10'h000, 1'b1);
    step(10'h200, 1'b1);
    step(10'h2AA, 1'b1);
    step_chk("rm_hdr",  10'h278, 1, 6'h3C, 2'b00, 6'b100000);
    step_chk("rm_idle", 10'h000, 0, 6'h3C, 2'b00, 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lin_header_receiver
